fpu_result_packer: RTL and testbench
====================================

FPU_RESULT_PACKER -- requirements
Module: fpu_result_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning output buffer entries (fixed at 2 in this revision).
REQ-002 SHALL have port clock, input, 1, single system clock, rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, upstream result valid.
REQ-005 SHALL have port in_ready, output, 1, block accepts a result this cycle.
REQ-006 SHALL have port in_data, input, 32, FPU result in the custom format: [31] sign, [30:25] exponent with bias 31, [24:0] mantissa.
REQ-007 SHALL have port in_status, input, 4, FPU status code: 0001 exact, 1111 inexact, 0011 overflow, 0111 underflow.
REQ-008 SHALL have port out_valid, output, 1, packed result available.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-010 SHALL have port out_data, output, 32, IEEE-754 binary32 result.
REQ-011 SHALL have port out_status, output, 4, per-result status code.
REQ-012 SHALL have port flags_clear, input, 1, clear sticky flags.
REQ-013 SHALL have port sticky_flags, output, 4, {invalid, overflow, underflow, inexact} accumulated since the last clear.

Function
REQ-014 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-015 The pipeline SHALL be stage S1 (captured input register), then the round/pack logic, then a 2-entry output FIFO.
REQ-016 in_ready SHALL be 1 when s1_valid plus fifo_count, minus a pop in the same cycle, is less than 2.
REQ-017 Latency: a result accepted at edge k SHALL enter the FIFO at edge k+1, and out_valid SHALL be 1 after edge k+1 when the FIFO was otherwise empty.
REQ-018 Order SHALL be preserved. There SHALL be no drops and no duplicates. out_data and out_status SHALL be held stable while out_valid=1 and out_ready=0.
REQ-019 Zero: exponent 0 and mantissa 0 SHALL produce {sign, 31'b0}.
REQ-020 Infinity: exponent 63 and mantissa 0 SHALL produce {sign, 8'hFF, 23'b0}.
REQ-021 Otherwise the IEEE exponent SHALL be the custom exponent + 96 (9-bit arithmetic, range 96..160), with never a denormal and never a NaN.
REQ-022 Mantissa SHALL be rounded to nearest-even: keep m[24:2], guard=m[1], sticky=m[0], round up if guard AND (sticky OR m[2]).
REQ-023 A mantissa carry-out SHALL zero the fraction and add 1 to the exponent.
REQ-024 Rounding inexact SHALL be set when m[1:0] != 0.
REQ-025 out_status SHALL equal in_status, except that 0001 with rounding inexact SHALL become 1111.
REQ-026 An in_status not in {0001, 1111, 0011, 0111} SHALL be passed through and SHALL set sticky invalid.
REQ-027 sticky_flags SHALL OR in the event bits of each result as it is written to the FIFO.
REQ-028 flags_clear SHALL zero sticky_flags at the next edge; when a clear and a set coincide, the new set bits SHALL survive.
REQ-029 Simultaneous push and pop on a full FIFO SHALL NOT occur, because in_ready gating prevents it. Simultaneous push and pop at count 1 SHALL keep the count at 1.
REQ-030 FIFO read and write pointers SHALL be 1-bit and wrap modulo 2.

Reset
REQ-031 While reset=0, in_ready, out_valid, s1_valid, fifo_count and all pointers SHALL be 0.
REQ-032 While reset=0, out_data, out_status and sticky_flags SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight and buffered results.
REQ-034 in_ready SHALL rise at the first edge after reset is released.

Structure
REQ-035 Package fpu_pkg SHALL hold CUST_BIAS=31, IEEE_BIAS=127, EXP_OFFSET=96, the custom field widths (1/6/25) and the status codes ST_EXACT, ST_INEXACT, ST_OVF, ST_UNF.
REQ-036 Sub-module fpu_res_fifo SHALL be the 2-entry FIFO for {data[31:0], status[3:0]}, with push/pop/count. The round/pack logic SHALL be combinational inside fpu_result_packer.

Verification
REQ-037 in_data 0x3E000000, status 0001 -> out_data 0x3F800000, out_status 0001, sticky 0000.
REQ-038 in_data 0x3E000003 -> out_data 0x3F800001, out_status 1111. in_data 0x3E000002 (tie, even) -> out_data 0x3F800000, sticky inexact=1.
REQ-039 in_data 0x3FFFFFFF (carry) -> out_data 0x40000000, out_status 1111. in_data 0x7E000000, status 0011 -> out_data 0x7F800000, sticky overflow=1.
REQ-040 in_data 0x80000000, status 0111 -> out_data 0x80000000, sticky underflow=1. status 0101 -> sticky invalid=1. flags_clear -> sticky 0000.
REQ-041 Hold out_ready=0 and offer 4 results -> exactly 2 accepted and in_ready=0. Release out_ready -> the 4 results come out in order with none lost and none repeated, and out_data is stable while stalled.
REQ-042 Assert reset mid-stream with 2 results buffered -> out_valid=0 and sticky=0 immediately; in_ready=1 after release; no stale output appears.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU result packer: custom-format field
// widths, exponent biases, status codes and the buffered result record.
package fpu_pkg;

   localparam int CUST_BIAS  = 31;
   localparam int IEEE_BIAS  = 127;
   localparam int EXP_OFFSET = IEEE_BIAS - CUST_BIAS;

   localparam int SIGN_W = 1;
   localparam int EXP_W  = 6;
   localparam int MANT_W = 25;

   localparam logic [3:0] ST_EXACT   = 4'b0001;
   localparam logic [3:0] ST_INEXACT = 4'b1111;
   localparam logic [3:0] ST_OVF     = 4'b0011;
   localparam logic [3:0] ST_UNF     = 4'b0111;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  status;
   } res_t;

   function automatic logic status_known(input logic [3:0] st);
      return (st == ST_EXACT) || (st == ST_INEXACT) || (st == ST_OVF) || (st == ST_UNF);
   endfunction

endpackage

// File: rtl/fpu_res_fifo.sv
// Two-entry result FIFO with 1-bit wrapping pointers; the head entry is
// presented combinationally so it stays stable until popped.
module fpu_res_fifo
   import fpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  res_t                         wr_data,
   output res_t                         rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);

   res_t          mem_q [2];
   res_t          mem_d [2];
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: rtl/fpu_result_packer.sv
// Converts custom-format FPU results to IEEE binary32 with round-to-nearest-even,
// tracks sticky exception flags, and buffers results in a 2-entry output FIFO.
module fpu_result_packer
   import fpu_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [3:0]  in_status,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_status,
   input  logic        flags_clear,
   output logic [3:0]  sticky_flags
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic              s1_valid_q, s1_valid_d;
   logic [31:0]       s1_data_q, s1_data_d;
   logic [3:0]        s1_status_q, s1_status_d;
   logic              run_q, run_d;
   logic [3:0]        sticky_q, sticky_d;

   logic [CW-1:0]     fifo_count;
   logic [2:0]        occupancy;
   logic              push, pop;
   res_t              push_res, head;

   logic [SIGN_W-1:0] sign;
   logic [EXP_W-1:0]  c_exp;
   logic [MANT_W-1:0] c_mant;
   logic              round_up, rnd_inexact;
   logic [23:0]       frac_sum;
   logic [7:0]        i_exp;
   logic [31:0]       packed_data;
   logic [3:0]        packed_status, events;

   // Round/pack of the S1 register; carry out of the fraction bumps the exponent.
   always_comb begin
      sign          = s1_data_q[31];
      c_exp         = s1_data_q[30 -: EXP_W];
      c_mant        = s1_data_q[MANT_W-1:0];
      round_up      = c_mant[1] & (c_mant[0] | c_mant[2]);
      rnd_inexact   = |c_mant[1:0];
      frac_sum      = {1'b0, c_mant[24:2]} + {23'b0, round_up};
      i_exp         = {2'b0, c_exp} + 8'(EXP_OFFSET) + {7'b0, frac_sum[23]};
      if (c_exp == '0 && c_mant == '0) begin
         packed_data = {sign, 31'b0};
      end else if (c_exp == '1 && c_mant == '0) begin
         packed_data = {sign, 8'hFF, 23'b0};
      end else begin
         packed_data = {sign, i_exp, frac_sum[22:0]};
      end
      packed_status = (s1_status_q == ST_EXACT && rnd_inexact) ? ST_INEXACT : s1_status_q;
      events        = {!status_known(s1_status_q),
                       s1_status_q == ST_OVF,
                       s1_status_q == ST_UNF,
                       rnd_inexact | (s1_status_q == ST_INEXACT)};
   end

   // S1 always drains into the FIFO next cycle; in_ready gating guarantees room.
   always_comb begin
      push      = s1_valid_q;
      out_valid = (fifo_count != '0);
      pop       = out_valid & out_ready;
      occupancy = 3'(s1_valid_q) + 3'(fifo_count) - 3'(pop);
      in_ready  = run_q && (occupancy < 3'd2);
      push_res  = '{data: packed_data, status: packed_status};

      run_d       = 1'b1;
      s1_valid_d  = in_valid & in_ready;
      s1_data_d   = s1_data_q;
      s1_status_d = s1_status_q;
      if (in_valid && in_ready) begin
         s1_data_d   = in_data;
         s1_status_d = in_status;
      end
      sticky_d = (flags_clear ? 4'b0 : sticky_q) | (push ? events : 4'b0);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         run_q       <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_status_q <= '0;
         sticky_q    <= '0;
      end else begin
         run_q       <= run_d;
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_status_q <= s1_status_d;
         sticky_q    <= sticky_d;
      end
   end

   fpu_res_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .wr_data (push_res),
      .rd_data (head),
      .count   (fifo_count)
   );

   assign out_data     = head.data;
   assign out_status   = head.status;
   assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fpu_result_packer.sv
// Directed and randomized checks of fpu_result_packer against an arithmetic
// reference model and a queue of in-flight results.
module tb_fpu_result_packer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [3:0]  in_status = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_status;
   logic        flags_clear = 1'b0;
   logic [3:0]  sticky_flags;

   fpu_result_packer #(.FIFO_DEPTH(2)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_status    (in_status),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_status   (out_status),
      .flags_clear  (flags_clear),
      .sticky_flags (sticky_flags)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  s;
      int          e;
   } item_t;

   item_t       sb[$];
   int          tests = 0;
   int          fails = 0;
   int          edges = 0;
   int          since_rst = 0;
   int          pop_cnt = 0;
   bit          last_acc;
   logic [3:0]  sticky_exp = '0;
   logic [3:0]  pend_ev = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: integer round-half-even on the mantissa divided by 4.
   task automatic ref_pack(input logic [31:0] d, input logic [3:0] st,
                           output logic [31:0] od, output logic [3:0] os, output logic [3:0] ev);
      int  e, m, q, r, ex;
      bit  inexact;
      e = int'(d[30:25]);
      m = int'(d[24:0]);
      q = m / 4;
      r = m % 4;
      inexact = (r != 0);
      if (e == 0 && m == 0) od = {d[31], 31'b0};
      else if (e == 63 && m == 0) od = {d[31], 8'hFF, 23'b0};
      else begin
         if (r > 2 || (r == 2 && (q % 2) == 1)) q = q + 1;
         ex = e + 96;
         if (q == (1 << 23)) begin
            q = 0;
            ex = ex + 1;
         end
         od = {d[31], ex[7:0], q[22:0]};
      end
      os = (st == 4'b0001 && inexact) ? 4'b1111 : st;
      ev[3] = !(st == 4'b0001 || st == 4'b1111 || st == 4'b0011 || st == 4'b0111);
      ev[2] = (st == 4'b0011);
      ev[1] = (st == 4'b0111);
      ev[0] = inexact || (st == 4'b1111);
   endtask

   // One clock: check outputs mid-cycle, log transfers, advance the model.
   task automatic tick();
      logic        exp_ov, exp_ir;
      logic [31:0] od;
      logic [3:0]  os, ev;
      int          occ;
      @(negedge clock);
      exp_ov = (sb.size() > 0) && (sb[0].e < edges);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
         chk("out_data", out_data, sb[0].d);
         chk("out_status", out_status, sb[0].s);
      end
      occ = sb.size() - ((exp_ov && out_ready) ? 1 : 0);
      exp_ir = (since_rst >= 1) && (occ < 2);
      chk("in_ready", in_ready, exp_ir);
      last_acc = in_valid && in_ready;
      ev = '0;
      if (last_acc) begin
         ref_pack(in_data, in_status, od, os, ev);
         sb.push_back('{d: od, s: os, e: edges + 1});
         $display("[TB] accept in_data=%h in_status=%b", in_data, in_status);
      end
      if (out_valid && out_ready) begin
         $display("[TB] output out_data=%h out_status=%b", out_data, out_status);
         if (sb.size() > 0) void'(sb.pop_front());
         pop_cnt++;
      end
      sticky_exp = (flags_clear ? 4'b0 : sticky_exp) | pend_ev;
      pend_ev = ev;
      @(posedge clock);
      edges++;
      since_rst++;
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic [3:0] st);
      bit ok = 0;
      in_valid = 1'b1;
      in_data = d;
      in_status = st;
      for (int i = 0; i < 10 && !ok; i++) begin
         tick();
         ok = last_acc;
      end
      in_valid = 1'b0;
      chk("send_accepted", 32'(ok), 32'd1);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
      tick();
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic clear_flags();
      flags_clear = 1'b1;
      tick();
      flags_clear = 1'b0;
      tick();
      chk("sticky_cleared", 32'(sticky_flags), 32'(sticky_exp));
   endtask

   function automatic logic [3:0] pick_status();
      int r = $urandom_range(0, 9);
      case (r)
         0, 1, 2: return 4'b0001;
         3, 4:    return 4'b1111;
         5:       return 4'b0011;
         6:       return 4'b0111;
         default: return 4'($urandom);
      endcase
   endfunction

   logic [31:0] vec_d [7] = '{32'h3E000000, 32'h3E000003, 32'h3E000002, 32'h3FFFFFFF,
                              32'h7E000000, 32'h80000000, 32'h3E000000};
   logic [3:0]  vec_s [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0111, 4'b0101};
   logic [31:0] items [4];

   initial begin
      int n;
      // Reset state
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_status", 32'(out_status), 32'd0);
      chk("rst_sticky", 32'(sticky_flags), 32'd0);
      @(posedge clock);
      #1 reset = 1'b1;
      since_rst = 0;

      // Directed conversion vectors, each drained and followed by a flag check
      for (int v = 0; v < 7; v++) begin
         out_ready = 1'b1;
         send(vec_d[v], vec_s[v]);
         drain();
         chk("sticky_vec", 32'(sticky_flags), 32'(sticky_exp));
         clear_flags();
      end

      // Clear coinciding with a flag set: the new bit survives
      send(32'h7E000000, 4'b0011);
      drain();
      in_valid = 1'b1;
      in_data = 32'h80000000;
      in_status = 4'b0111;
      tick();
      in_valid = 1'b0;
      flags_clear = 1'b1;
      tick();
      flags_clear = 1'b0;
      drain();
      chk("sticky_clear_vs_set", 32'(sticky_flags), 32'(sticky_exp));
      clear_flags();

      // Stalled output: only two results fit
      for (int i = 0; i < 4; i++) items[i] = $urandom;
      out_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         in_valid = (n < 4);
         in_data = items[n % 4];
         in_status = 4'b0001;
         tick();
         if (last_acc) n++;
      end
      chk("stall_accepted", 32'(n), 32'd2);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      pop_cnt = 0;
      for (int i = 0; i < 30 && !(n == 4 && sb.size() == 0); i++) begin
         in_valid = (n < 4);
         in_data = items[n % 4];
         tick();
         if (last_acc) n++;
      end
      in_valid = 1'b0;
      chk("stall_all_out", 32'(pop_cnt), 32'd4);
      drain();
      clear_flags();

      // Randomized traffic with random backpressure
      for (int i = 0; i < 300; i++) begin
         if (!in_valid || last_acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = $urandom;
            in_status = pick_status();
         end
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      in_valid = 1'b0;
      drain();
      chk("sticky_random", 32'(sticky_flags), 32'(sticky_exp));

      // Reset mid-stream with two results buffered
      out_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         in_valid = (n < 2);
         in_data = $urandom;
         in_status = 4'b1111;
         tick();
         if (last_acc) n++;
      end
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_sticky", 32'(sticky_flags), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      chk("midrst_out_data", out_data, 32'd0);
      sb.delete();
      sticky_exp = '0;
      pend_ev = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      since_rst = 0;
      out_ready = 1'b1;
      repeat (4) tick();
      send(32'h3E000003, 4'b0001);
      drain();
      chk("post_rst_sticky", 32'(sticky_flags), 32'(sticky_exp));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
